fpga_shift_transmitter: RTL and testbench



---
 rtl/fpga_comm_pkg.sv | 19 +
 rtl/fpga_bit_timer.sv | 42 ++++
 rtl/fpga_shift_transmitter.sv | 132 +++++++++++++
 tb/tb_fpga_shift_transmitter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_comm_pkg.sv
// Shared types and default constants for the FPGA-to-FPGA serial link.
package fpga_comm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    localparam int unsigned FPGA_DATA_WIDTH = 8;
    localparam int unsigned FPGA_BIT_PERIOD = 4;
    localparam int unsigned FPGA_GAP_CYCLES = 2;

    // Counter width for a modulo-v count, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fpga_bit_timer.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while enabled and ticks on the last count.
module fpga_bit_timer
    import fpga_comm_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = FPGA_BIT_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = clog2_min1(BIT_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        tick      = 1'b0;
        if (clr) begin
            cyc_cnt_d = '0;
        end else if (en) begin
            if (cyc_cnt_q == LAST) begin
                tick      = 1'b1;
                cyc_cnt_d = '0;
            end else begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

endmodule

// File: rtl/fpga_shift_transmitter.sv
// Serial link transmitter: valid/ready word in, MSB-first bits out with a per-bit shift strobe.
// Define FPGA_TX_PARITY_EN to append an even-parity bit after the LSB.
module fpga_shift_transmitter
    import fpga_comm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FPGA_DATA_WIDTH,
    parameter int unsigned BIT_PERIOD = FPGA_BIT_PERIOD,
    parameter int unsigned GAP_CYCLES = FPGA_GAP_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  serial_out,
    output logic                  shift_out,
    output logic                  busy,
    output logic                  done
);

`ifdef FPGA_TX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned    FW       = DATA_WIDTH + PAR;
    localparam int unsigned    BCW      = $clog2(FW + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FW - 1);
    localparam int unsigned    GCW      = clog2_min1(GAP_CYCLES);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t      state_q, state_d;
    logic [FW-1:0]  shreg_q, shreg_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic           serial_q, serial_d;
    logic           done_q, done_d;
    logic [FW-1:0]  capture;
    logic           tick;

    fpga_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD)
    ) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .en    (state_q == SHIFT),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    always_comb begin
`ifdef FPGA_TX_PARITY_EN
        capture = {data_in, ^data_in};
`else
        capture = data_in;
`endif
    end

    // serial_q is loaded one edge ahead so it already holds the next bit when the strobe fires.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        serial_d  = serial_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                serial_d = 1'b0;
                if (load) begin
                    shreg_d   = capture;
                    bit_cnt_d = '0;
                    serial_d  = capture[FW-1];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    shreg_d   = {shreg_q[FW-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        done_d    = 1'b1;
                        serial_d  = 1'b0;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        serial_d = shreg_q[FW-2];
                    end
                end
            end
            GAP: begin
                serial_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        ready      = (state_q == IDLE);
        busy       = (state_q != IDLE);
        serial_out = serial_q;
        shift_out  = tick;
        done       = done_q;
    end

endmodule

// File: tb/tb_fpga_shift_transmitter.sv
// Directed bench for fpga_shift_transmitter; output vector order is {ready, busy, serial_out, shift_out, done}.
module tb_fpga_shift_transmitter;

`ifdef FPGA_TX_PARITY_EN
    localparam int PAR_TB = 1;
`else
    localparam int PAR_TB = 0;
`endif
    localparam int NB = 8 + PAR_TB;
    localparam int BP = 4;
    localparam int GP = 2;
    localparam int FE = NB * BP;
    localparam int F  = FE + GP + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       load  = 1'b0;
    logic       ready, ser, sh, busy, dn;
    logic [7:0] data1 = 8'h00;
    logic       load1 = 1'b0;
    logic       ready1, ser1, sh1, busy1, dn1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpga_shift_transmitter #(
        .DATA_WIDTH (8),
        .BIT_PERIOD (BP),
        .GAP_CYCLES (GP)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .data_in    (data),
        .load       (load),
        .ready      (ready),
        .serial_out (ser),
        .shift_out  (sh),
        .busy       (busy),
        .done       (dn)
    );

    fpga_shift_transmitter #(
        .DATA_WIDTH (8),
        .BIT_PERIOD (1),
        .GAP_CYCLES (0)
    ) dut1 (
        .clock      (clk),
        .reset      (rst_n),
        .data_in    (data1),
        .load       (load1),
        .ready      (ready1),
        .serial_out (ser1),
        .shift_out  (sh1),
        .busy       (busy1),
        .done       (dn1)
    );

    function automatic logic frame_bit(input logic [7:0] w, input int b);
        if (b < 8) return w[7-b];
        return ^w;
    endfunction

    // Expected outputs in cycle l (l >= 1) after the acceptance edge.
    function automatic logic [4:0] exp_vec(input logic [7:0] w, input int l, input int bp, input int gp);
        int   fe;
        logic r;
        fe = NB * bp;
        r  = (l > fe + gp);
        return {r, !r, (l <= fe) ? frame_bit(w, (l - 1) / bp) : 1'b0,
                (l <= fe) && (l % bp == 0), l == fe + 1};
    endfunction

    task automatic test_reset();
        #7;
        n_checks++;
        if ({ready, busy, ser, sh, dn} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", {ready, busy, ser, sh, dn}, 5'b10000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame_a5();
        int strobes = 0;
        @(negedge clk);
        data = 8'hA5;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int l = 1; l <= F; l++) begin
            @(negedge clk);
            strobes += int'(sh);
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== exp_vec(8'hA5, l, BP, GP)) begin
                n_fail++;
                $display("FAIL frame_a5 cycle %0d: got %b expected %b", l,
                         {ready, busy, ser, sh, dn}, exp_vec(8'hA5, l, BP, GP));
            end
        end
        n_checks++;
        if (strobes != NB) begin
            n_fail++;
            $display("FAIL frame_a5_strobes: got %0d expected %0d", strobes, NB);
        end
    endtask

    task automatic test_load_ignored();
        int strobes = 0;
        @(negedge clk);
        data = 8'h5A;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int l = 1; l <= F; l++) begin
            @(negedge clk);
            if (l == 11) load = 1'b0;
            strobes += int'(sh);
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== exp_vec(8'h5A, l, BP, GP)) begin
                n_fail++;
                $display("FAIL load_ignored cycle %0d: got %b expected %b", l,
                         {ready, busy, ser, sh, dn}, exp_vec(8'h5A, l, BP, GP));
            end
            if (l == 10) begin
                data = 8'h3C;
                load = 1'b1;
            end
        end
        n_checks++;
        if (strobes != NB) begin
            n_fail++;
            $display("FAIL load_ignored_strobes: got %0d expected %0d", strobes, NB);
        end
    endtask

    task automatic test_back_to_back();
        int         strobes = 0;
        int         loc;
        logic [7:0] w;
        @(negedge clk);
        data = 8'hFF;
        load = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2 * F; c++) begin
            @(negedge clk);
            if (c == 1) data = 8'h00;
            if (c == F + 1) load = 1'b0;
            loc = (c <= F) ? c : c - F;
            w   = (c <= F) ? 8'hFF : 8'h00;
            strobes += int'(sh);
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== exp_vec(w, loc, BP, GP)) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", c,
                         {ready, busy, ser, sh, dn}, exp_vec(w, loc, BP, GP));
            end
        end
        n_checks++;
        if (strobes != 2 * NB) begin
            n_fail++;
            $display("FAIL back_to_back_strobes: got %0d expected %0d", strobes, 2 * NB);
        end
    endtask

    task automatic test_reset_mid_frame();
        int strobes = 0;
        @(negedge clk);
        data = 8'hA5;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int l = 1; l <= 13; l++) begin
            @(negedge clk);
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== exp_vec(8'hA5, l, BP, GP)) begin
                n_fail++;
                $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", l,
                         {ready, busy, ser, sh, dn}, exp_vec(8'hA5, l, BP, GP));
            end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ready, busy, ser, sh, dn} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_async_clear: got %b expected %b", {ready, busy, ser, sh, dn}, 5'b10000);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int l = 1; l <= 20; l++) begin
            @(negedge clk);
            strobes += int'(sh);
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_post_idle cycle %0d: got %b expected %b", l,
                         {ready, busy, ser, sh, dn}, 5'b10000);
            end
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL reset_post_strobes: got %0d expected 0", strobes);
        end
    endtask

    task automatic test_bp1_gap0();
        int strobes = 0;
        @(negedge clk);
        data1 = 8'h81;
        load1 = 1'b1;
        @(posedge clk);
        #1 load1 = 1'b0;
        for (int l = 1; l <= NB + 2; l++) begin
            @(negedge clk);
            strobes += int'(sh1);
            n_checks++;
            if ({ready1, busy1, ser1, sh1, dn1} !== exp_vec(8'h81, l, 1, 0)) begin
                n_fail++;
                $display("FAIL bp1_gap0 cycle %0d: got %b expected %b", l,
                         {ready1, busy1, ser1, sh1, dn1}, exp_vec(8'h81, l, 1, 0));
            end
        end
        n_checks++;
        if (strobes != NB) begin
            n_fail++;
            $display("FAIL bp1_gap0_strobes: got %0d expected %0d", strobes, NB);
        end
    endtask

`ifdef FPGA_TX_PARITY_EN
    task automatic test_parity();
        int   strobes = 0;
        logic last_bit = 1'b0;
        @(negedge clk);
        data = 8'h07;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        for (int l = 1; l <= F; l++) begin
            @(negedge clk);
            strobes += int'(sh);
            if (l == FE) last_bit = ser;
            n_checks++;
            if ({ready, busy, ser, sh, dn} !== exp_vec(8'h07, l, BP, GP)) begin
                n_fail++;
                $display("FAIL parity cycle %0d: got %b expected %b", l,
                         {ready, busy, ser, sh, dn}, exp_vec(8'h07, l, BP, GP));
            end
        end
        n_checks++;
        if (strobes != 9 || last_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bit: got %0d strobes bit %b expected 9 strobes bit 1", strobes, last_bit);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_a5();
        test_load_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_bp1_gap0();
`ifdef FPGA_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
